// File: rtl/hc21_ste_pkg.sv
// hc21_ste_pkg: shared STE bus definitions for the watchdog and the CPU interface stage.
//   ste_state_e  - watchdog transfer state encoding
//   ste_cm_e     - STE command line (cm[2:0]) codes
//   st_is_fail() - true for states that report a transfer error
package hc21_ste_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_ACK  = 3'd2,
        ST_ERR  = 3'd3,
        ST_TOUT = 3'd4
    } ste_state_e;

    typedef enum logic [2:0] {
        CM_VECTOR_RD = 3'b000,
        CM_RSVD_1    = 3'b001,
        CM_RSVD_2    = 3'b010,
        CM_RSVD_3    = 3'b011,
        CM_IO_WR     = 3'b100,
        CM_IO_RD     = 3'b101,
        CM_MEM_WR    = 3'b110,
        CM_MEM_RD    = 3'b111
    } ste_cm_e;

    localparam int ERRLOG_W = 8;

    function automatic logic st_is_fail(input ste_state_e s);
        return (s == ST_ERR) || (s == ST_TOUT);
    endfunction

endpackage

// File: rtl/hc21_sync_n.sv
// hc21_sync_n: multi-flop synchroniser for an asynchronous active-low signal.
//   clk_i  - destination clock
//   rst_i  - synchronous active-high reset, all stages reset to 1 (inactive)
//   d_i    - asynchronous input
//   q_o    - synchronised output, STAGES cycles behind d_i
module hc21_sync_n #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] ff_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) ff_q <= '1;
        else       ff_q <= {ff_q[STAGES-2:0], d_i};
    end

    assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/hc21_ste_bus_watchdog.sv
// hc21_ste_bus_watchdog: STE bus transfer watchdog qualifying slave ack/error and forcing a
// transfer error when no slave answers within TIMEOUT_CYCLES.
//   sysclk        - system clock, rising edge
//   sysrst        - synchronous active-high reset
//   busstb_n      - strobe from CPU interface stage (active low, synchronous)
//   cm[2:0]       - command lines, captured at strobe start
//   ste_datack_n  - raw backplane acknowledge (asynchronous, active low)
//   ste_tfrerr_n  - raw backplane transfer error (asynchronous, active low)
//   datack_n      - qualified acknowledge (registered, active low)
//   tfrerr_n      - qualified slave/timeout error (registered, active low)
//   busy          - high in every state except IDLE
//   timeout_pulse - one-cycle pulse on watchdog expiry, aligned with tfrerr_n assertion
// Optional (macro HC21_STE_ERRLOG_EN):
//   err_count[7:0] - saturating count of failed transfers
//   err_cm[2:0]    - cm of the last failed transfer
module hc21_ste_bus_watchdog
    import hc21_ste_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       sysclk,
    input  logic       sysrst,
    input  logic       busstb_n,
    input  logic [2:0] cm,
    input  logic       ste_datack_n,
    input  logic       ste_tfrerr_n,
    output logic       datack_n,
    output logic       tfrerr_n,
    output logic       busy,
    output logic       timeout_pulse
`ifdef HC21_STE_ERRLOG_EN
    ,
    output logic [ERRLOG_W-1:0] err_count,
    output logic [2:0]          err_cm
`endif
);

    localparam int           CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TC = CW'(TIMEOUT_CYCLES - 1);

    logic       ack_s_n, err_s_n;
    ste_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] cm_q, cm_d;
    logic       datack_n_q, tfrerr_n_q, timeout_pulse_q;

    hc21_sync_n #(.STAGES(SYNC_STAGES)) u_sync_ack (
        .clk_i (sysclk),
        .rst_i (sysrst),
        .d_i   (ste_datack_n),
        .q_o   (ack_s_n)
    );

    hc21_sync_n #(.STAGES(SYNC_STAGES)) u_sync_err (
        .clk_i (sysclk),
        .rst_i (sysrst),
        .d_i   (ste_tfrerr_n),
        .q_o   (err_s_n)
    );

    // In WAIT an abort wins, then error over ack, then ack over the terminal count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cm_d    = cm_q;
        case (state_q)
            ST_IDLE: begin
                if (!busstb_n) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                    cm_d    = cm;
                end
            end
            ST_WAIT: begin
                cnt_d = (cnt_q == TC) ? cnt_q : cnt_q + CW'(1);
                if (busstb_n)          state_d = ST_IDLE;
                else if (!err_s_n)     state_d = ST_ERR;
                else if (!ack_s_n)     state_d = ST_ACK;
                else if (cnt_q == TC)  state_d = ST_TOUT;
            end
            default: begin
                if (busstb_n) state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs follow state_q by one cycle; tfrerr_n_q is still high only on the
    // first TOUT cycle, which makes the pulse single-cycle and aligned with tfrerr_n.
    always_ff @(posedge sysclk) begin
        if (sysrst) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            cm_q            <= '0;
            datack_n_q      <= 1'b1;
            tfrerr_n_q      <= 1'b1;
            timeout_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            cm_q            <= cm_d;
            datack_n_q      <= (state_q != ST_ACK);
            tfrerr_n_q      <= !st_is_fail(state_q);
            timeout_pulse_q <= (state_q == ST_TOUT) && tfrerr_n_q;
        end
    end

    assign datack_n      = datack_n_q;
    assign tfrerr_n      = tfrerr_n_q;
    assign timeout_pulse = timeout_pulse_q;
    assign busy          = (state_q != ST_IDLE);

`ifdef HC21_STE_ERRLOG_EN
    logic [ERRLOG_W-1:0] err_count_q;
    logic [2:0]          err_cm_q;

    always_ff @(posedge sysclk) begin
        if (sysrst) begin
            err_count_q <= '0;
            err_cm_q    <= '0;
        end else if (state_q == ST_WAIT && st_is_fail(state_d)) begin
            err_count_q <= (&err_count_q) ? err_count_q : err_count_q + ERRLOG_W'(1);
            err_cm_q    <= cm_q;
        end
    end

    assign err_count = err_count_q;
    assign err_cm    = err_cm_q;
`else
    // The captured command is only consumed by the error log.
    logic unused_cm;
    assign unused_cm = ^cm_q;
`endif

endmodule

// File: tb/tb_hc21_ste_bus_watchdog.sv
// tb_hc21_ste_bus_watchdog: self-checking bench for hc21_ste_bus_watchdog (directed table,
// multi-cycle corner sequences, randomized traffic against a transaction-level model).
module tb_hc21_ste_bus_watchdog;

    localparam int T = 16;
    localparam int S = 2;

    logic       sysclk = 1'b0;
    logic       sysrst, busstb_n, ste_datack_n, ste_tfrerr_n;
    logic [2:0] cm;
    logic       datack_n, tfrerr_n, busy, timeout_pulse;
`ifdef HC21_STE_ERRLOG_EN
    logic [7:0] err_count;
    logic [2:0] err_cm;
`endif

    int n_chk = 0;
    int n_err = 0;

    hc21_ste_bus_watchdog #(.TIMEOUT_CYCLES(T), .SYNC_STAGES(S)) dut (
        .sysclk        (sysclk),
        .sysrst        (sysrst),
        .busstb_n      (busstb_n),
        .cm            (cm),
        .ste_datack_n  (ste_datack_n),
        .ste_tfrerr_n  (ste_tfrerr_n),
        .datack_n      (datack_n),
        .tfrerr_n      (tfrerr_n),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
`ifdef HC21_STE_ERRLOG_EN
        ,
        .err_count     (err_count),
        .err_cm        (err_cm)
`endif
    );

    always #5 sysclk = ~sysclk;

    // Transaction-level reference: a transfer is open or not, and once open it has
    // an outcome (0 none, 1 ack, 2 error, 3 timeout). Backplane inputs are seen S edges late.
    logic [S-1:0] m_sh_ack, m_sh_err;
    bit        m_open, m_new_tout;
    int        m_outcome, m_waited;
    logic [2:0] m_cm;
    logic      exp_dn, exp_te, exp_p, exp_busy;
    int        m_ecnt;
    logic [2:0] m_ecm;
    bit        chk_model = 0;

    task automatic log_fail();
        if (m_ecnt < 255) m_ecnt++;
        m_ecm = m_cm;
    endtask

    task automatic model_edge();
        logic seen_ack, seen_err;
        if (sysrst) begin
            m_sh_ack = '1; m_sh_err = '1;
            m_open = 0; m_new_tout = 0; m_outcome = 0; m_waited = 0; m_cm = 0;
            exp_dn = 1; exp_te = 1; exp_p = 0;
            m_ecnt = 0; m_ecm = 0;
        end else begin
            seen_ack = m_sh_ack[S-1];
            seen_err = m_sh_err[S-1];
            m_sh_ack = {m_sh_ack[S-2:0], ste_datack_n};
            m_sh_err = {m_sh_err[S-2:0], ste_tfrerr_n};
            exp_dn = !(m_open && m_outcome == 1);
            exp_te = !(m_open && m_outcome >= 2);
            exp_p  = m_new_tout;
            m_new_tout = 0;
            if (!m_open) begin
                if (!busstb_n) begin
                    m_open = 1; m_outcome = 0; m_waited = 0; m_cm = cm;
                end
            end else if (m_outcome == 0) begin
                if (busstb_n) m_open = 0;
                else if (!seen_err) begin m_outcome = 2; log_fail(); end
                else if (!seen_ack) m_outcome = 1;
                else if (m_waited == T - 1) begin m_outcome = 3; m_new_tout = 1; log_fail(); end
                else m_waited++;
            end else if (busstb_n) begin
                m_open = 0;
            end
        end
        exp_busy = m_open;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge sysclk);
        model_edge();
        #1;
        if (chk_model) begin
            chk("rand.datack_n", datack_n, exp_dn);
            chk("rand.tfrerr_n", tfrerr_n, exp_te);
            chk("rand.busy", busy, exp_busy);
            chk("rand.timeout_pulse", timeout_pulse, exp_p);
`ifdef HC21_STE_ERRLOG_EN
            chk("rand.err_count", err_count, m_ecnt);
            chk("rand.err_cm", err_cm, m_ecm);
`endif
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic a, input logic e, input logic [2:0] c);
        sysrst = r; busstb_n = s; ste_datack_n = a; ste_tfrerr_n = e; cm = c;
    endtask

    typedef struct {
        logic rst, stb, ack, err;
        logic [2:0] cm;
        logic dn, te, bsy, p;
    } vec_t;

    vec_t tv [19];

    initial begin
        int pulse_at, npulse, ack_at;
        bit quiet;
        drive(1, 1, 1, 1, 0);

        // rst stb ack err cm | datack_n tfrerr_n busy pulse
        tv[0]  = '{1, 1, 1, 1, 3'd0, 1, 1, 0, 0};
        tv[1]  = '{0, 0, 1, 1, 3'd0, 1, 1, 1, 0};
        tv[2]  = '{0, 0, 0, 1, 3'd0, 1, 1, 1, 0};
        tv[3]  = '{0, 0, 0, 1, 3'd0, 1, 1, 1, 0};
        tv[4]  = '{0, 0, 0, 1, 3'd0, 1, 1, 1, 0};
        tv[5]  = '{0, 0, 0, 1, 3'd0, 0, 1, 1, 0};
        tv[6]  = '{0, 1, 1, 1, 3'd0, 0, 1, 0, 0};
        tv[7]  = '{0, 1, 1, 1, 3'd0, 1, 1, 0, 0};
        tv[8]  = '{0, 0, 1, 1, 3'd3, 1, 1, 1, 0};
        tv[9]  = '{0, 0, 0, 0, 3'd3, 1, 1, 1, 0};
        tv[10] = '{0, 0, 0, 0, 3'd3, 1, 1, 1, 0};
        tv[11] = '{0, 0, 0, 0, 3'd3, 1, 1, 1, 0};
        tv[12] = '{0, 0, 0, 0, 3'd3, 1, 0, 1, 0};
        tv[13] = '{0, 1, 1, 1, 3'd3, 1, 0, 0, 0};
        tv[14] = '{0, 1, 1, 1, 3'd0, 1, 1, 0, 0};
        tv[15] = '{0, 0, 1, 1, 3'd5, 1, 1, 1, 0};
        tv[16] = '{0, 0, 1, 1, 3'd5, 1, 1, 1, 0};
        tv[17] = '{0, 1, 1, 1, 3'd5, 1, 1, 0, 0};
        tv[18] = '{0, 1, 1, 1, 3'd5, 1, 1, 0, 0};

        for (int i = 0; i < 19; i++) begin
            drive(tv[i].rst, tv[i].stb, tv[i].ack, tv[i].err, tv[i].cm);
            step();
            chk($sformatf("vec%0d.datack_n", i), datack_n, tv[i].dn);
            chk($sformatf("vec%0d.tfrerr_n", i), tfrerr_n, tv[i].te);
            chk($sformatf("vec%0d.busy", i), busy, tv[i].bsy);
            chk($sformatf("vec%0d.timeout_pulse", i), timeout_pulse, tv[i].p);
        end
`ifdef HC21_STE_ERRLOG_EN
        chk("vec.err_count", err_count, 1);
        chk("vec.err_cm", err_cm, 3);
`endif

        // Watchdog expiry with no slave answer.
        drive(1, 1, 1, 1, 0); step();
        drive(0, 0, 1, 1, 3'd6);
        pulse_at = -1; npulse = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (timeout_pulse === 1'b1) begin
                npulse++;
                if (pulse_at < 0) pulse_at = k;
            end
        end
        chk("tout.pulse_cycle", pulse_at, T + 1);
        chk("tout.pulse_count", npulse, 1);
        chk("tout.tfrerr_n", tfrerr_n, 0);
        chk("tout.datack_n", datack_n, 1);
        busstb_n = 1; step();
        chk("tout.release_tfrerr_n", tfrerr_n, 0);
        chk("tout.release_busy", busy, 0);
        step();
        chk("tout.after_tfrerr_n", tfrerr_n, 1);

        // Ack latency: raw ack five edges after the strobe edge.
        drive(1, 1, 1, 1, 0); step();
        drive(0, 0, 1, 1, 3'd7);
        ack_at = -1; npulse = 0;
        for (int k = 0; k < 20; k++) begin
            if (k == 5) ste_datack_n = 0;
            step();
            if (datack_n === 1'b0 && ack_at < 0) ack_at = k;
            if (timeout_pulse === 1'b1) npulse++;
        end
        chk("lat.ack_cycle", ack_at, 5 + S + 1);
        chk("lat.tfrerr_n", tfrerr_n, 1);
        chk("lat.no_pulse", npulse, 0);
        drive(0, 1, 1, 1, 0); step(); step();

        // Ack seen on the terminal-count cycle beats the timeout.
        drive(1, 1, 1, 1, 0); step();
        drive(0, 0, 1, 1, 3'd1);
        npulse = 0;
        for (int k = 0; k < 20; k++) begin
            if (k == T - S) ste_datack_n = 0;
            step();
            if (timeout_pulse === 1'b1) npulse++;
        end
        chk("tc_ack.datack_n", datack_n, 0);
        chk("tc_ack.tfrerr_n", tfrerr_n, 1);
        chk("tc_ack.no_pulse", npulse, 0);

        // Reset mid-ACK, then a still-low strobe restarts on the first free edge.
        sysrst = 1; step();
        chk("rst_ack.datack_n", datack_n, 1);
        chk("rst_ack.busy", busy, 0);
        chk("rst_ack.tfrerr_n", tfrerr_n, 1);
        drive(0, 0, 1, 1, 0); step();
        chk("rst_rel.busy", busy, 1);
        chk("rst_rel.datack_n", datack_n, 1);
        busstb_n = 1; step();
        chk("rst_rel.abort_busy", busy, 0);

        // Randomized traffic against the reference model.
        drive(1, 1, 1, 1, 0); step();
        sysrst = 0;
        chk_model = 1;
        quiet = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 48 == 0) quiet = ($urandom_range(0, 2) == 0);
            sysrst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 11) == 0) busstb_n = ~busstb_n;
            ste_datack_n = quiet ? 1'b1 : ($urandom_range(0, 5) != 0);
            ste_tfrerr_n = quiet ? 1'b1 : ($urandom_range(0, 11) != 0);
            cm = 3'($urandom_range(0, 7));
            step();
        end
        chk_model = 0;

`ifdef HC21_STE_ERRLOG_EN
        // Back-to-back timeouts saturate the error counter.
        drive(1, 1, 1, 1, 0); step();
        sysrst = 0;
        for (int n = 0; n < 300; n++) begin
            busstb_n = 0;
            for (int k = 0; k < T + 2; k++) step();
            busstb_n = 1;
            step(); step();
        end
        chk("sat.err_count", err_count, 255);
        chk("sat.err_cm", err_cm, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
